// File: rtl/matrix2x2_mult_core.sv
// Sequential 2x2 signed matrix multiply, C = A x B.
// A single multiplier/accumulator is time-shared over eight MAC steps.
module matrix2x2_mult_core #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 2*DATA_WIDTH+1
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4*DATA_WIDTH-1:0]  in_a,
    input  logic [4*DATA_WIDTH-1:0]  in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [4*OUT_WIDTH-1:0]   out_c,
    output logic                     busy
);

    localparam int DW = DATA_WIDTH;
    localparam int OW = OUT_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            step_q, step_d;
    logic signed [OW-1:0]  acc_q, acc_d;
    logic [4*DW-1:0]       a_q, a_d;
    logic [4*DW-1:0]       b_q, b_d;
    logic [4*OW-1:0]       c_q, c_d;
    logic                  out_valid_q, out_valid_d;

    logic [1:0]            e_idx;
    logic                  i_sel, j_sel, k_sel;
    logic [1:0]            a_idx, b_idx;
    logic signed [DW-1:0]  mul_a, mul_b;
    logic signed [2*DW-1:0] prod;
    logic signed [OW-1:0]  prod_x;
    logic signed [OW-1:0]  sum;

    // step[2:1] picks the C element, step[0] picks the inner-product term
    always_comb begin
        e_idx  = step_q[2:1];
        i_sel  = e_idx[1];
        j_sel  = e_idx[0];
        k_sel  = step_q[0];
        a_idx  = {i_sel, k_sel};
        b_idx  = {k_sel, j_sel};
        mul_a  = a_q[32'(a_idx)*DW +: DW];
        mul_b  = b_q[32'(b_idx)*DW +: DW];
        prod   = mul_a * mul_b;
        prod_x = {{(OW-2*DW){prod[2*DW-1]}}, prod};
        sum    = acc_q + prod_x;
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        acc_d       = acc_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    step_d  = 3'd0;
                    acc_d   = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (!k_sel) begin
                    acc_d = prod_x;
                end else begin
                    c_d[32'(e_idx)*OW +: OW] = sum;
                end
                step_d = step_q + 3'd1;
                if (step_q == 3'd7) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= IDLE;
            step_q      <= 3'd0;
            acc_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !ARESET;
    assign busy      = (state_q != IDLE) && !ARESET;
    assign out_valid = out_valid_q;
    assign out_c     = c_q;

endmodule

// File: tb/tb_matrix2x2_mult_core.sv
// Bench for matrix2x2_mult_core: directed corner cases plus a
// randomized stream checked against a plain-arithmetic matrix model.
module tb_matrix2x2_mult_core;

    localparam int DW = 8;
    localparam int OW = 2*DW+1;

    logic            ACLK = 1'b0;
    logic            ARESET = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [4*DW-1:0] in_a = '0;
    logic [4*DW-1:0] in_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [4*OW-1:0] out_c;
    logic            busy;

    int errors = 0;
    int checks = 0;

    matrix2x2_mult_core #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .busy      (busy)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    function automatic logic [4*OW-1:0] ref_mult(input logic [4*DW-1:0] a,
                                                 input logic [4*DW-1:0] b);
        int am[2][2];
        int bm[2][2];
        logic signed [DW-1:0] t;
        logic [4*OW-1:0] r;
        int v;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                t = a[(2*i+j)*DW +: DW];
                am[i][j] = t;
                t = b[(2*i+j)*DW +: DW];
                bm[i][j] = t;
            end
        end
        r = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                v = am[i][0]*bm[0][j] + am[i][1]*bm[1][j];
                r[(2*i+j)*OW +: OW] = v[OW-1:0];
            end
        end
        return r;
    endfunction

    // Offer one beat, wait for acceptance, then wait for out_valid.
    task automatic run_op(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b,
                          output int cyc, output bit accepted);
        int n;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        accepted = in_ready;
        tick();
        in_valid = 1'b0;
        in_a = $urandom;
        in_b = $urandom;
        cyc = 0;
        while (cyc < 30) begin
            tick();
            cyc++;
            if (out_valid) break;
        end
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_out_valid got=%b exp=0", out_valid);
            end
            checks++;
            if (out_c !== '0) begin
                errors++;
                $display("FAIL rst_out_c got=%h exp=0", out_c);
            end
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL rst_in_ready got=%b exp=0", in_ready);
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_busy got=%b exp=0", busy);
            end
        end
        ARESET = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [4*OW-1:0] exp_c;
        int cyc;
        exp_c = {17'd50, 17'd43, 17'd22, 17'd19};
        out_ready = 1'b1;
        in_a = {8'd4, 8'd3, 8'd2, 8'd1};
        in_b = {8'd8, 8'd7, 8'd6, 8'd5};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_a = $urandom;
        in_b = $urandom;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy ready=%b busy=%b exp ready=0 busy=1",
                     in_ready, busy);
        end
        cyc = 0;
        while (cyc < 30) begin
            tick();
            cyc++;
            if (out_valid) break;
        end
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL basic_latency got=%0d exp=8", cyc);
        end
        checks++;
        if (out_c !== exp_c) begin
            errors++;
            $display("FAIL basic_c got=%h exp=%h", out_c, exp_c);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_1cyc valid=%b ready=%b busy=%b exp 0 1 0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_boundary();
        logic [4*OW-1:0] exp_c;
        int cyc;
        bit acc;
        out_ready = 1'b1;
        exp_c = {4{17'h08000}};
        run_op({4{8'h80}}, {4{8'h80}}, cyc, acc);
        checks++;
        if (!acc || cyc !== 8 || out_c !== exp_c) begin
            errors++;
            $display("FAIL bound_min acc=%b cyc=%0d got=%h exp=%h",
                     acc, cyc, out_c, exp_c);
        end
        tick();
        exp_c = {17'h1FF80, 17'h0007F, 17'h00007, 17'h1FFFF};
        run_op({8'd1, 8'd0, 8'd0, 8'd1}, {8'h80, 8'd127, 8'd7, 8'hFF}, cyc, acc);
        checks++;
        if (!acc || cyc !== 8 || out_c !== exp_c) begin
            errors++;
            $display("FAIL bound_ident acc=%b cyc=%0d got=%h exp=%h",
                     acc, cyc, out_c, exp_c);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [4*DW-1:0] a1, b1, a2, b2;
        logic [4*OW-1:0] e1, e2;
        int cyc;
        bit acc;
        a1 = $urandom;
        b1 = $urandom;
        a2 = $urandom;
        b2 = $urandom;
        e1 = ref_mult(a1, b1);
        e2 = ref_mult(a2, b2);
        out_ready = 1'b0;
        run_op(a1, b1, cyc, acc);
        checks++;
        if (!acc || cyc !== 8 || out_c !== e1) begin
            errors++;
            $display("FAIL bp_first acc=%b cyc=%0d got=%h exp=%h",
                     acc, cyc, out_c, e1);
        end
        in_a = a2;
        in_b = b2;
        in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_c !== e1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d valid=%b ready=%b got=%h exp=%h",
                         n, out_valid, in_ready, out_c, e1);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release valid=%b ready=%b exp 0 1",
                     out_valid, in_ready);
        end
        tick();
        in_valid = 1'b0;
        in_a = $urandom;
        in_b = $urandom;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_second_accept busy=%b exp=1", busy);
        end
        cyc = 0;
        while (cyc < 30) begin
            tick();
            cyc++;
            if (out_valid) break;
        end
        checks++;
        if (cyc !== 8 || out_c !== e2) begin
            errors++;
            $display("FAIL bp_second cyc=%0d got=%h exp=%h", cyc, out_c, e2);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [4*DW-1:0] a, b;
        logic [4*OW-1:0] e;
        int cyc;
        bit acc;
        bit seen;
        out_ready = 1'b1;
        in_a = $urandom;
        in_b = $urandom;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        ARESET = 1'b1;
        tick();
        checks++;
        if (out_c !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state c=%h valid=%b busy=%b ready=%b exp 0 0 0 0",
                     out_c, out_valid, busy, in_ready);
        end
        ARESET = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_valid got=%b exp=0", seen);
        end
        a = $urandom;
        b = $urandom;
        e = ref_mult(a, b);
        run_op(a, b, cyc, acc);
        checks++;
        if (!acc || cyc !== 8 || out_c !== e) begin
            errors++;
            $display("FAIL midrst_next acc=%b cyc=%0d got=%h exp=%h",
                     acc, cyc, out_c, e);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [4*OW-1:0] expq[$];
        logic [4*DW-1:0] pa, pb;
        bit have_beat;
        int sent, recvd, cyc;
        sent = 0;
        recvd = 0;
        have_beat = 1'b0;
        pa = '0;
        pb = '0;
        cyc = 0;
        while (recvd < 100 && cyc < 6000) begin
            if (!have_beat && sent < 100 && $urandom_range(0, 3) != 0) begin
                pa = $urandom;
                pb = $urandom;
                have_beat = 1'b1;
            end
            in_valid = have_beat;
            in_a = have_beat ? pa : 32'($urandom);
            in_b = have_beat ? pb : 32'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (in_valid && in_ready) begin
                expq.push_back(ref_mult(pa, pb));
                have_beat = 1'b0;
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected idx=%0d got=%h", recvd, out_c);
                end else if (out_c !== expq[0]) begin
                    errors++;
                    $display("FAIL b2b_data idx=%0d got=%h exp=%h",
                             recvd, out_c, expq[0]);
                end
                if (expq.size() != 0) void'(expq.pop_front());
                recvd++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (recvd != 100 || sent != 100 || expq.size() != 0) begin
            errors++;
            $display("FAIL b2b_count recvd=%0d sent=%0d left=%0d exp 100 100 0",
                     recvd, sent, expq.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
